// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// lab2_proc_mem_arbiter_pkg: 4B memory message types and source IDs shared by the arbiter slice.
package lab2_proc_mem_arb_pkg;

    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ  = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic {SRC_IMEM = 1'b0, SRC_DMEM = 1'b1} src_t;

endpackage

// File: rtl/lab2_proc_mem_arbiter_if.sv
// lab2_proc_mem_arbiter_if: imem/dmem/mem request and response streams around the arbiter.
interface lab2_proc_mem_arbiter_if #(parameter int p_max_outstanding = 4);
    lab2_proc_mem_arb_pkg::mem_req_4B_t  imem_reqstream_msg, dmem_reqstream_msg, mem_reqstream_msg;
    lab2_proc_mem_arb_pkg::mem_resp_4B_t imem_respstream_msg, dmem_respstream_msg, mem_respstream_msg;
    logic imem_reqstream_val, imem_reqstream_rdy, dmem_reqstream_val, dmem_reqstream_rdy;
    logic imem_respstream_val, imem_respstream_rdy, dmem_respstream_val, dmem_respstream_rdy;
    logic mem_reqstream_val, mem_reqstream_rdy, mem_respstream_val, mem_respstream_rdy;
    logic [$clog2(p_max_outstanding+1)-1:0] num_outstanding;

    modport slave (
        input  imem_reqstream_msg, imem_reqstream_val, dmem_reqstream_msg, dmem_reqstream_val,
        output imem_reqstream_rdy, dmem_reqstream_rdy,
        output imem_respstream_msg, imem_respstream_val, dmem_respstream_msg, dmem_respstream_val,
        input  imem_respstream_rdy, dmem_respstream_rdy,
        output mem_reqstream_msg, mem_reqstream_val, mem_respstream_rdy, num_outstanding,
        input  mem_reqstream_rdy, mem_respstream_msg, mem_respstream_val
    );

    modport master (
        output imem_reqstream_msg, imem_reqstream_val, dmem_reqstream_msg, dmem_reqstream_val,
        input  imem_reqstream_rdy, dmem_reqstream_rdy,
        input  imem_respstream_msg, imem_respstream_val, dmem_respstream_msg, dmem_respstream_val,
        output imem_respstream_rdy, dmem_respstream_rdy,
        input  mem_reqstream_msg, mem_reqstream_val, mem_respstream_rdy, num_outstanding,
        output mem_reqstream_rdy, mem_respstream_msg, mem_respstream_val
    );
endinterface

// File: rtl/lab2_proc_mem_arbiter_tracker.sv
// lab2_proc_mem_arbiter_tracker: in-order 1-bit source-ID queue reporting its free-entry count.
module lab2_proc_mem_arbiter_tracker #(
    parameter int p_depth = 4,
    localparam int CW = $clog2(p_depth + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq,
    input  logic          enq_msg,
    input  logic          deq,
    output logic          deq_msg,
    output logic [CW-1:0] num_free_entries
);
    localparam int AW = p_depth > 1 ? $clog2(p_depth) : 1;

    logic [p_depth-1:0] ids;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(p_depth - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                ids[wr_ptr] <= enq_msg;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (deq)
                rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign deq_msg          = ids[rd_ptr];
    assign num_free_entries = CW'(p_depth) - count;
endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// lab2_proc_mem_arbiter: shares one 4B memory port between imem and dmem, routing responses in order.
// LAB2_PROC_MEM_ARB_FIXED_PRIO_EN selects fixed dmem priority instead of round-robin.
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arb_pkg::*;
#(
    parameter int p_max_outstanding = 4
) (
    input logic                    clk,
    input logic                    reset,
    lab2_proc_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(p_max_outstanding + 1);

    logic [CW-1:0] num_free;
    logic          head, full, empty, req_go, resp_go;
    src_t          grant;

    lab2_proc_mem_arbiter_tracker #(.p_depth(p_max_outstanding)) u_tracker (
        .clk              (clk),
        .reset            (reset),
        .enq              (req_go),
        .enq_msg          (grant),
        .deq              (resp_go),
        .deq_msg          (head),
        .num_free_entries (num_free)
    );

`ifdef LAB2_PROC_MEM_ARB_FIXED_PRIO_EN
    assign grant = bus.dmem_reqstream_val ? SRC_DMEM : SRC_IMEM;
`else
    src_t last_grant;

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= SRC_IMEM;
        else if (req_go)
            last_grant <= grant;
    end

    // A stalled winner keeps the grant because last_grant only moves on a handshake.
    assign grant = (bus.imem_reqstream_val & bus.dmem_reqstream_val)
                 ? (last_grant == SRC_IMEM ? SRC_DMEM : SRC_IMEM)
                 : (bus.dmem_reqstream_val ? SRC_DMEM : SRC_IMEM);
`endif

    always_comb begin
        full                    = num_free == '0;
        empty                   = num_free == CW'(p_max_outstanding);
        bus.mem_reqstream_val   = ~reset & ~full & (bus.imem_reqstream_val | bus.dmem_reqstream_val);
        bus.mem_reqstream_msg   = grant == SRC_DMEM ? bus.dmem_reqstream_msg : bus.imem_reqstream_msg;
        bus.imem_reqstream_rdy  = ~reset & ~full & bus.mem_reqstream_rdy & (grant == SRC_IMEM);
        bus.dmem_reqstream_rdy  = ~reset & ~full & bus.mem_reqstream_rdy & (grant == SRC_DMEM);
        req_go                  = bus.mem_reqstream_val & bus.mem_reqstream_rdy;
        bus.imem_respstream_msg = bus.mem_respstream_msg;
        bus.dmem_respstream_msg = bus.mem_respstream_msg;
        bus.imem_respstream_val = ~reset & ~empty & bus.mem_respstream_val & (head == SRC_IMEM);
        bus.dmem_respstream_val = ~reset & ~empty & bus.mem_respstream_val & (head == SRC_DMEM);
        bus.mem_respstream_rdy  = ~reset & ~empty
                                & (head == SRC_DMEM ? bus.dmem_respstream_rdy : bus.imem_respstream_rdy);
        resp_go                 = bus.mem_respstream_val & bus.mem_respstream_rdy;
        bus.num_outstanding     = reset ? '0 : CW'(p_max_outstanding) - num_free;
    end
endmodule
